// File: rtl/led_fade_pkg.sv
// Shared types and saturating duty arithmetic for the LED breathing sequencer.
package led_fade_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RAMP_UP   = 3'd1,
    HOLD_HIGH = 3'd2,
    RAMP_DOWN = 3'd3,
    HOLD_LOW  = 3'd4
  } led_fade_state_t;

  // Duty math runs one bit wider than the widest supported duty word (16 bits).
  localparam int unsigned LF_ARITH_W = 17;

  function automatic logic [LF_ARITH_W-1:0] lf_add_clamp(
    input logic [LF_ARITH_W-1:0] a,
    input logic [LF_ARITH_W-1:0] b,
    input logic [LF_ARITH_W-1:0] hi
  );
    logic [LF_ARITH_W-1:0] sum;
    sum = a + b;
    if (sum > hi) begin
      return hi;
    end else begin
      return sum;
    end
  endfunction

  function automatic logic [LF_ARITH_W-1:0] lf_sub_clamp(
    input logic [LF_ARITH_W-1:0] a,
    input logic [LF_ARITH_W-1:0] b,
    input logic [LF_ARITH_W-1:0] lo
  );
    logic [LF_ARITH_W-1:0] diff;
    if (a >= b) begin
      diff = a - b;
    end else begin
      diff = {LF_ARITH_W{1'b0}};
    end
    if (diff < lo) begin
      return lo;
    end else begin
      return diff;
    end
  endfunction

endpackage

// File: rtl/led_fade_prescaler.sv
// Step-period prescaler: emits a one-cycle tick every period+1 enabled cycles.
module led_fade_prescaler
  import led_fade_pkg::*;
#(
  parameter int unsigned width_p = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               en,
  input  logic [width_p-1:0] period,
  output logic               tick
);

  logic [width_p-1:0] count_q;
  logic [width_p-1:0] count_d;

  // Compare with >= so a period shrunk below the running count still ticks.
  always_comb begin
    tick    = 1'b0;
    count_d = count_q;
    if (clear) begin
      count_d = {width_p{1'b0}};
    end else if (en) begin
      if (count_q >= period) begin
        tick    = 1'b1;
        count_d = {width_p{1'b0}};
      end else begin
        count_d = count_q + width_p'(1);
      end
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= {width_p{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/led_fade_ctrl.sv
// Breathing-effect duty sequencer feeding the PWM block.
// Optional gamma stage selected by LED_FADE_GAMMA_EN (duty = lin^2 >> width, +1 clk).
module led_fade_ctrl
  import led_fade_pkg::*;
#(
  parameter int unsigned counter_width_p   = 8,
  parameter int unsigned prescaler_width_p = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_enable,
  input  logic [counter_width_p-1:0]   cfg_step,
  input  logic [prescaler_width_p-1:0] cfg_step_period,
  input  logic [counter_width_p-1:0]   cfg_min_duty,
  input  logic [counter_width_p-1:0]   cfg_max_duty,
  input  logic [prescaler_width_p-1:0] cfg_hold_high,
  input  logic [prescaler_width_p-1:0] cfg_hold_low,
  output logic [counter_width_p-1:0]   duty_o,
  output logic [2:0]                   state_o,
  output logic                         cycle_done_o
);

  localparam int unsigned CW = counter_width_p;
  localparam int unsigned PW = prescaler_width_p;
  localparam int unsigned AW = LF_ARITH_W;

  led_fade_state_t state_q, state_d;
  logic [CW-1:0]   lin_q, lin_d;
  logic [PW-1:0]   hold_q, hold_d;
  logic            cycle_done_q, cycle_done_d;

  logic            tick_s;
  logic            presc_clear_s;
  logic            presc_en_s;
  logic [CW-1:0]   step_eff_s;
  logic [AW-1:0]   up_s;
  logic [AW-1:0]   dn_s;
  logic [CW-1:0]   up_lin_s;
  logic [CW-1:0]   dn_lin_s;

  // Prescaler control and clamped next-duty candidates.
  always_comb begin
    presc_en_s    = (state_q != IDLE);
    presc_clear_s = (state_q == IDLE) && cfg_enable;
    if (cfg_step == {CW{1'b0}}) begin
      step_eff_s = CW'(1);
    end else begin
      step_eff_s = cfg_step;
    end
    up_s     = lf_add_clamp(AW'(lin_q), AW'(step_eff_s), AW'(cfg_max_duty));
    dn_s     = lf_sub_clamp(AW'(lin_q), AW'(step_eff_s), AW'(cfg_min_duty));
    up_lin_s = up_s[CW-1:0];
    dn_lin_s = dn_s[CW-1:0];
  end

  led_fade_prescaler #(
    .width_p (PW)
  ) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .clear  (presc_clear_s),
    .en     (presc_en_s),
    .period (cfg_step_period),
    .tick   (tick_s)
  );

  // Next-state logic; a dropped enable overrides any pending tick.
  always_comb begin
    state_d      = state_q;
    lin_d        = lin_q;
    hold_d       = hold_q;
    cycle_done_d = 1'b0;
    if (!cfg_enable) begin
      state_d = IDLE;
      lin_d   = {CW{1'b0}};
      hold_d  = {PW{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          state_d = RAMP_UP;
          lin_d   = cfg_min_duty;
          hold_d  = {PW{1'b0}};
        end
        RAMP_UP: begin
          if (tick_s) begin
            lin_d = up_lin_s;
            if (up_lin_s == cfg_max_duty) begin
              state_d = HOLD_HIGH;
              hold_d  = {PW{1'b0}};
            end else begin
              state_d = RAMP_UP;
            end
          end else begin
            lin_d = lin_q;
          end
        end
        HOLD_HIGH: begin
          if (tick_s) begin
            if (hold_q == cfg_hold_high) begin
              state_d = RAMP_DOWN;
            end else begin
              hold_d = hold_q + PW'(1);
            end
          end else begin
            hold_d = hold_q;
          end
        end
        RAMP_DOWN: begin
          if (tick_s) begin
            lin_d = dn_lin_s;
            if (dn_lin_s == cfg_min_duty) begin
              state_d = HOLD_LOW;
              hold_d  = {PW{1'b0}};
            end else begin
              state_d = RAMP_DOWN;
            end
          end else begin
            lin_d = lin_q;
          end
        end
        HOLD_LOW: begin
          if (tick_s) begin
            if (hold_q == cfg_hold_low) begin
              state_d      = RAMP_UP;
              cycle_done_d = 1'b1;
            end else begin
              hold_d = hold_q + PW'(1);
            end
          end else begin
            hold_d = hold_q;
          end
        end
        default: begin
          state_d = IDLE;
          lin_d   = {CW{1'b0}};
          hold_d  = {PW{1'b0}};
        end
      endcase
    end
  end

  // FSM, linear duty, hold counter and cycle pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      lin_q        <= {CW{1'b0}};
      hold_q       <= {PW{1'b0}};
      cycle_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      lin_q        <= lin_d;
      hold_q       <= hold_d;
      cycle_done_q <= cycle_done_d;
    end
  end

`ifdef LED_FADE_GAMMA_EN
  logic [2*CW-1:0] sq_s;
  logic [CW-1:0]   duty_q, duty_d;

  // Squaring curve: upper half of lin*lin.
  always_comb begin
    sq_s   = {{CW{1'b0}}, lin_q} * {{CW{1'b0}}, lin_q};
    duty_d = sq_s[2*CW-1:CW];
  end

  // Gamma output stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      duty_q <= {CW{1'b0}};
    end else begin
      duty_q <= duty_d;
    end
  end

  assign duty_o = duty_q;
`else
  assign duty_o = lin_q;
`endif

  assign state_o      = state_q;
  assign cycle_done_o = cycle_done_q;

endmodule
